// File: rtl/edge_event_arbiter_if.sv
// Event port of the edge-event arbiter: one valid/ready channel carrying a
// channel id and the edge polarity of the offered event.
interface edge_event_arbiter_if #(
    parameter int IDW = 2
);
    logic           evt_valid_o;
    logic           evt_ready_i;
    logic [IDW-1:0] evt_id_o;
    logic           evt_rise_o;

    modport master (
        output evt_valid_o,
        output evt_id_o,
        output evt_rise_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_id_o,
        input  evt_rise_o,
        output evt_ready_i
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector. Each detected edge is latched as one pending
// event per channel; pending events are offered one at a time on a valid/ready
// port in round-robin order. Edges that hit an occupied slot are counted as
// dropped in a saturating counter.
module edge_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int CW  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        sig_i,
    input  logic [N-1:0]        rise_en_i,
    input  logic [N-1:0]        fall_en_i,
    output logic [N-1:0]        pending_o,
    output logic [CW-1:0]       drop_cnt_o,
    edge_event_arbiter_if.master evt
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   sig_ff, pend, ptype;
    logic [N-1:0]   rise, fall, det, moved, drop;
    logic [IDW-1:0] ptr, sel, rr_idx, evt_id;
    logic           evt_rise, found, any_pend, accept, load;
    logic [CW-1:0]  drop_cnt;

    // Adds one per set bit of inc to the counter, clamping at all-ones.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [N-1:0] inc);
        int sum;
        sum = int'(a);
        for (int i = 0; i < N; i++) sum += int'(inc[i]);
        if (sum > (1 << CW) - 1) return {CW{1'b1}};
        return CW'(sum);
    endfunction

    assign rise     = ~sig_ff & sig_i & rise_en_i;
    assign fall     = sig_ff & ~sig_i & fall_en_i;
    assign det      = rise | fall;
    assign any_pend = |pend;
    assign accept   = (state == OFFER) & evt.evt_ready_i;
    assign moved    = load ? (N'(1) << sel) : '0;
    // A slot being moved out this cycle is free, so its new edge is not a drop.
    assign drop     = det & pend & ~moved;

    // Round-robin pick: first pending channel at or after ptr, wrapping.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = IDW'((int'(ptr) + k) % N);
            if (!found && pend[rr_idx]) begin
                sel   = rr_idx;
                found = 1'b1;
            end
        end
    end

    // Output FSM next state; load moves the selected event into the output register.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    load     = 1'b1;
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    if (any_pend) load = 1'b1;
                    else          state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Previous-cycle copy of the input lines for edge detection.
    always_ff @(posedge clk) begin
        if (reset) sig_ff <= '0;
        else       sig_ff <= sig_i;
    end

    // Pending flags: set on a captured edge, cleared when moved to the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (det[i] && (!pend[i] || moved[i])) pend[i] <= 1'b1;
                else if (moved[i])                    pend[i] <= 1'b0;
            end
        end
    end

    // Edge polarity of each pending event; only meaningful while pend is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (det[i] && (!pend[i] || moved[i])) ptype[i] <= rise[i];
        end
    end

    // Output register and round-robin pointer, updated on every load.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_id   <= '0;
            evt_rise <= 1'b0;
            ptr      <= '0;
        end else if (load) begin
            evt_id   <= sel;
            evt_rise <= ptype[sel];
            ptr      <= (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
        end
    end

    // Saturating count of edges discarded because their slot was occupied.
    always_ff @(posedge clk) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= sat_add(drop_cnt, drop);
    end

    assign evt.evt_valid_o = (state == OFFER);
    assign evt.evt_id_o    = evt_id;
    assign evt.evt_rise_o  = evt_rise;
    assign pending_o       = pend;
    assign drop_cnt_o      = drop_cnt;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: two instances (CW=8 and CW=2) share the same
// stimulus and are compared every cycle against an event-level reference model,
// plus directed scenarios with fixed expected values.
module tb_edge_event_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sig, rise_en, fall_en;
    logic         ready;
    logic [N-1:0] pending, pending_s;
    logic [7:0]   drop_cnt;
    logic [1:0]   drop_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_event_arbiter_if #(.IDW(IDW)) evt_if ();
    edge_event_arbiter_if #(.IDW(IDW)) evt_if_s ();
    assign evt_if.evt_ready_i   = ready;
    assign evt_if_s.evt_ready_i = ready;

    edge_event_arbiter #(.N(N), .IDW(IDW), .CW(8)) dut (
        .clk(clk), .reset(reset), .sig_i(sig), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .pending_o(pending), .drop_cnt_o(drop_cnt), .evt(evt_if.master)
    );

    edge_event_arbiter #(.N(N), .IDW(IDW), .CW(2)) dut_s (
        .clk(clk), .reset(reset), .sig_i(sig), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .pending_o(pending_s), .drop_cnt_o(drop_cnt_s), .evt(evt_if_s.master)
    );

    // Reference model state: per-channel slots, the offered event, pointer, drop total.
    bit m_prev [N];
    bit m_pend [N];
    bit m_ptype[N];
    bit m_valid = 0;
    bit m_rise  = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_drops = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock of the event-level behaviour, using the inputs present at the edge.
    task automatic model_step();
        bit accept, any, r, f;
        bit moved[N];
        int sel;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
            end
            m_valid = 0; m_rise = 0; m_id = 0; m_ptr = 0; m_drops = 0;
            return;
        end
        accept = m_valid && ready;
        any = 0;
        for (int i = 0; i < N; i++) begin
            moved[i] = 0;
            if (m_pend[i]) any = 1;
        end
        if ((!m_valid || accept) && any) begin
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && m_pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            m_id = sel;
            m_rise = m_ptype[sel];
            moved[sel] = 1;
            m_ptr = (sel + 1) % N;
            m_valid = 1;
        end else if (accept) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            r = !m_prev[i] && sig[i] && rise_en[i];
            f = m_prev[i] && !sig[i] && fall_en[i];
            if (r || f) begin
                if (!m_pend[i] || moved[i]) begin
                    m_pend[i] = 1;
                    m_ptype[i] = r;
                end else begin
                    m_drops++;
                end
            end else if (moved[i]) begin
                m_pend[i] = 0;
            end
            m_prev[i] = sig[i];
        end
    endtask

    task automatic check_all();
        check_eq("valid",     evt_if.evt_valid_o,   m_valid);
        check_eq("id",        evt_if.evt_id_o,      m_id);
        check_eq("rise",      evt_if.evt_rise_o,    m_rise);
        check_eq("pending",   pending,              m_pend_vec());
        check_eq("drop",      drop_cnt,             (m_drops > 255) ? 255 : m_drops);
        check_eq("valid_s",   evt_if_s.evt_valid_o, m_valid);
        check_eq("id_s",      evt_if_s.evt_id_o,    m_id);
        check_eq("rise_s",    evt_if_s.evt_rise_o,  m_rise);
        check_eq("pending_s", pending_s,            m_pend_vec());
        check_eq("drop_s",    drop_cnt_s,           (m_drops > 3) ? 3 : m_drops);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sig = '0; rise_en = '0; fall_en = '0; ready = 1'b0;
        tick();

        // Reset state and first-event latency on channel 0
        rise_en = 4'b1111; ready = 1'b1;
        do_reset();
        check_eq("rst_valid", evt_if.evt_valid_o, 0);
        check_eq("rst_pend", pending, 0);
        sig = 4'b0001;
        tick();
        check_eq("t1_pend", pending, 4'b0001);
        check_eq("t1_v0", evt_if.evt_valid_o, 0);
        tick();
        check_eq("t1_v1", evt_if.evt_valid_o, 1);
        check_eq("t1_id", evt_if.evt_id_o, 0);
        check_eq("t1_rise", evt_if.evt_rise_o, 1);
        tick();
        check_eq("t1_v2", evt_if.evt_valid_o, 0);
        check_eq("t1_drop", drop_cnt, 0);

        // Channel 2 toggles high/low/high under back-pressure
        sig = '0; fall_en = 4'b1111; ready = 1'b0;
        do_reset();
        sig = 4'b0100; tick();
        sig = 4'b0000; tick();
        check_eq("t2_id", evt_if.evt_id_o, 2);
        check_eq("t2_rise", evt_if.evt_rise_o, 1);
        check_eq("t2_pend", pending, 4'b0100);
        sig = 4'b0100; tick();
        check_eq("t2_drop", drop_cnt, 1);
        check_eq("t2_valid", evt_if.evt_valid_o, 1);
        ready = 1'b1; tick();
        check_eq("t2_id2", evt_if.evt_id_o, 2);
        check_eq("t2_rise2", evt_if.evt_rise_o, 0);
        check_eq("t2_valid2", evt_if.evt_valid_o, 1);
        tick();
        check_eq("t2_idle", evt_if.evt_valid_o, 0);

        // Simultaneous edges on all channels, ptr=0 then ptr=2
        sig = '0; fall_en = '0; ready = 1'b1;
        do_reset();
        sig = 4'b1111; tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t3_rr0", evt_if.evt_id_o, k);
        end
        sig = '0;
        do_reset();
        sig = 4'b0010; tick(); tick(); tick();
        sig = 4'b0000; tick();
        sig = 4'b1111; tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t3_rr2", evt_if.evt_id_o, (k + 2) % 4);
        end

        // Back-pressure while offering channel 1
        sig = '0; ready = 1'b0;
        do_reset();
        sig = 4'b0010; tick(); tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t4_hold_v", evt_if.evt_valid_o, 1);
            check_eq("t4_hold_id", evt_if.evt_id_o, 1);
            check_eq("t4_hold_r", evt_if.evt_rise_o, 1);
        end
        ready = 1'b1; tick();
        check_eq("t4_done", evt_if.evt_valid_o, 0);

        // Counter saturation: seven drops on channel 0
        sig = '0; fall_en = 4'b1111; ready = 1'b0;
        do_reset();
        sig = 4'b0001; tick();
        sig = 4'b0000; tick();
        for (int k = 0; k < 7; k++) begin
            sig = sig ^ 4'b0001;
            tick();
        end
        check_eq("t5_drop8", drop_cnt, 7);
        check_eq("t5_drop2", drop_cnt_s, 3);

        // Reset while offering with a pending flag set
        sig = '0; tick();
        check_eq("t6_pre_v", evt_if.evt_valid_o, 1);
        reset = 1'b1; tick();
        check_eq("t6_v", evt_if.evt_valid_o, 0);
        check_eq("t6_id", evt_if.evt_id_o, 0);
        check_eq("t6_r", evt_if.evt_rise_o, 0);
        check_eq("t6_p", pending, 0);
        check_eq("t6_d", drop_cnt, 0);
        reset = 1'b0; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t6_quiet", evt_if.evt_valid_o, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(99) == 0);
            sig   = sig ^ (N'($urandom) & N'($urandom));
            if ($urandom_range(7) == 0) rise_en = N'($urandom);
            if ($urandom_range(7) == 0) fall_en = N'($urandom);
            ready = ($urandom_range(2) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
